// File: rtl/game_vga_pkg.sv
// Shared timing defaults (640x480@60) and counter types for the game VGA timing block.
package game_vga_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int H_FRONT       = 16;
  localparam int H_SYNC        = 96;
  localparam int H_BACK        = 48;
  localparam int V_FRONT       = 10;
  localparam int V_SYNC        = 2;
  localparam int V_BACK        = 33;
  localparam int H_TOTAL       = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL       = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;

  typedef logic [9:0] h_cnt_t;
  typedef logic [9:0] v_cnt_t;

endpackage

// File: rtl/game_vga_axis_counter.sv
// One display axis: counts visible+front+sync+back positions on step, decodes visible/sync.
module game_vga_axis_counter #(
  parameter int len_visible = 640,
  parameter int len_front   = 16,
  parameter int len_sync    = 96,
  parameter int len_back    = 48,
  parameter int w           = $clog2(len_visible + len_front + len_sync + len_back)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [w-1:0] count,
  output logic         visible,
  output logic         sync_n,
  output logic         wrap
);

  localparam int TOTAL = len_visible + len_front + len_sync + len_back;
  localparam logic [w-1:0] LAST       = w'(TOTAL - 1);
  localparam logic [w-1:0] VIS_END    = w'(len_visible);
  localparam logic [w-1:0] SYNC_START = w'(len_visible + len_front);
  localparam logic [w-1:0] SYNC_END   = w'(len_visible + len_front + len_sync);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

  assign wrap    = (count == LAST);
  assign visible = (count < VIS_END);
  assign sync_n  = !((count >= SYNC_START) && (count < SYNC_END));

endmodule

// File: rtl/game_vga_timing.sv
// 640x480@60 pixel-position generator for the game renderer (x, y, display_on, hsync, vsync).
// Define GAME_VGA_FRAME_COUNTER_EN to enable the 16-bit frame_count; otherwise it is tied to 0.
module game_vga_timing
  import game_vga_pkg::*;
#(
  parameter int clk_mhz       = 50,
  parameter int pixel_mhz     = 25,
  parameter int screen_width  = SCREEN_WIDTH,
  parameter int screen_height = SCREEN_HEIGHT,
  parameter int h_front       = H_FRONT,
  parameter int h_sync        = H_SYNC,
  parameter int h_back        = H_BACK,
  parameter int v_front       = V_FRONT,
  parameter int v_sync        = V_SYNC,
  parameter int v_back        = V_BACK,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pixel_en,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic [w_x-1:0] x,
  output logic [w_y-1:0] y,
  output logic           frame_start,
  output logic [15:0]    frame_count
);

  localparam int DIV     = clk_mhz / pixel_mhz;
  localparam int H_TOT   = screen_width + h_front + h_sync + h_back;
  localparam int V_TOT   = screen_height + v_front + v_sync + v_back;
  localparam int W_H     = $clog2(H_TOT);
  localparam int W_V     = $clog2(V_TOT);
  localparam int W_DIV   = (DIV > 1) ? $clog2(DIV) : 1;

  if (((clk_mhz % pixel_mhz) != 0) || (clk_mhz < pixel_mhz)) begin : g_bad_ratio
    $error("game_vga_timing: clk_mhz/pixel_mhz must be an integer >= 1");
  end

  logic [W_DIV-1:0] div_cnt;
  logic             tick;
  logic [W_H-1:0]   h_cnt;
  logic [W_V-1:0]   v_cnt;
  logic             h_vis, h_sync_n, h_wrap;
  logic             v_vis, v_sync_n, v_wrap;
  logic             vis;
  logic             at_origin;

  assign tick = (div_cnt == W_DIV'(DIV - 1));
  assign vis  = h_vis && v_vis;

  game_vga_axis_counter #(
    .len_visible(screen_width), .len_front(h_front), .len_sync(h_sync), .len_back(h_back), .w(W_H)
  ) u_h_axis (
    .clk(clk), .rst(rst), .step(tick),
    .count(h_cnt), .visible(h_vis), .sync_n(h_sync_n), .wrap(h_wrap)
  );

  game_vga_axis_counter #(
    .len_visible(screen_height), .len_front(v_front), .len_sync(v_sync), .len_back(v_back), .w(W_V)
  ) u_v_axis (
    .clk(clk), .rst(rst), .step(tick && h_wrap),
    .count(v_cnt), .visible(v_vis), .sync_n(v_sync_n), .wrap(v_wrap)
  );

  // The counters point at the pixel about to be presented: on each tick the outputs
  // latch the decode of (h_cnt, v_cnt) while the counters move on, so the first
  // strobe after reset shows (0,0) in the same clk as pixel_en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt     <= '0;
      pixel_en    <= 1'b0;
      display_on  <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      at_origin   <= 1'b1;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      pixel_en    <= tick;
      frame_start <= tick && at_origin;
      if (tick) begin
        display_on <= vis;
        x          <= vis ? w_x'(h_cnt) : '0;
        y          <= vis ? w_y'(v_cnt) : '0;
        hsync      <= h_sync_n;
        vsync      <= v_sync_n;
        at_origin  <= h_wrap && v_wrap;
      end
    end
  end

`ifdef GAME_VGA_FRAME_COUNTER_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (tick && at_origin) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_count = frame_cnt;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_game_vga_timing.sv
// Bench for game_vga_timing on a reduced screen geometry (DIV=2) so several whole frames fit.
// Expected outputs come from a closed-form pixel-index model; random mid-frame resets are applied.
module tb_game_vga_timing;

  localparam int CLK_MHZ = 50;
  localparam int PIX_MHZ = 25;
  localparam int DIV     = CLK_MHZ / PIX_MHZ;
  localparam int SW = 16, HF = 2, HS = 3, HB = 3;
  localparam int SH = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = SW + HF + HS + HB;
  localparam int VT = SH + VF + VS + VB;
  localparam int FRAME_PIX = HT * VT;
  localparam int FRAME_CLK = FRAME_PIX * DIV;
  localparam int WX = $clog2(SW);
  localparam int WY = $clog2(SH);

  typedef struct packed {
    logic          pixel_en;
    logic          hsync;
    logic          vsync;
    logic          display_on;
    logic          frame_start;
    logic [WX-1:0] x;
    logic [WY-1:0] y;
    logic [15:0]   frame_count;
  } vid_t;
  localparam int W = $bits(vid_t);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pixel_en, hsync, vsync, display_on, frame_start;
  logic [WX-1:0] x;
  logic [WY-1:0] y;
  logic [15:0]   frame_count;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  game_vga_timing #(
    .clk_mhz(CLK_MHZ), .pixel_mhz(PIX_MHZ),
    .screen_width(SW), .screen_height(SH),
    .h_front(HF), .h_sync(HS), .h_back(HB),
    .v_front(VF), .v_sync(VS), .v_back(VB),
    .w_x(WX), .w_y(WY)
  ) dut (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .x(x), .y(y), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // t = clks with rst high since release; pixel p is presented on clk (p+1)*DIV and held.
  function automatic vid_t model(input int t);
    vid_t r;
    int p, h, v;
    r = '0;
    r.hsync = 1'b1;
    r.vsync = 1'b1;
    if (t < DIV) return r;
    p = t / DIV - 1;
    h = p % HT;
    v = (p / HT) % VT;
    r.pixel_en    = (t % DIV) == 0;
    r.display_on  = (h < SW) && (v < SH);
    r.x           = r.display_on ? WX'(h) : '0;
    r.y           = r.display_on ? WY'(v) : '0;
    r.hsync       = !((h >= SW + HF) && (h < SW + HF + HS));
    r.vsync       = !((v >= SH + VF) && (v < SH + VF + VS));
    r.frame_start = r.pixel_en && ((p % FRAME_PIX) == 0);
`ifdef GAME_VGA_FRAME_COUNTER_EN
    r.frame_count = 16'(p / FRAME_PIX + 1);
`endif
    return r;
  endfunction

  int t_model = 0;
  always @(posedge clk) begin
    if (!rst) t_model = 0;
    else t_model = t_model + 1;
    exp_q.push_back(model(t_model));
  end

  // ---------------- scoreboard ----------------
  int   cyc = 0;
  int   last_fs = 0;
  bit   have_prev = 1'b0;
  int   hs_falls = 0;
  int   disp_px = 0;
  logic prev_hs = 1'b1;
  vid_t e;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      e = vid_t'(exp_q.pop_front());
      check_eq("pixel_en",    pixel_en,    e.pixel_en);
      check_eq("hsync",       hsync,       e.hsync);
      check_eq("vsync",       vsync,       e.vsync);
      check_eq("display_on",  display_on,  e.display_on);
      check_eq("frame_start", frame_start, e.frame_start);
      check_eq("x",           x,           e.x);
      check_eq("y",           y,           e.y);
      check_eq("frame_count", frame_count, e.frame_count);
    end
    if (!rst) begin
      have_prev = 1'b0;
    end else begin
      if (frame_start) begin
        if (have_prev) begin
          check_eq("frame_period", cyc - last_fs, FRAME_CLK);
          check_eq("hsync_pulses_per_frame", hs_falls, VT);
          check_eq("visible_strobes_per_frame", disp_px, SW * SH);
        end
        have_prev = 1'b1;
        last_fs   = cyc;
        hs_falls  = 0;
        disp_px   = 0;
      end
      if (prev_hs && !hsync) hs_falls++;
      if (pixel_en && display_on) disp_px++;
    end
    prev_hs = hsync;
  end

  // ---------------- driver ----------------
  task automatic run_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b0;
    run_clks(n);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    run_clks(10);
    rst = 1'b1;
    run_clks(3 * FRAME_CLK + FRAME_CLK / 2);
    // Directed one-clk reset mid-line, mid-frame.
    run_clks((5 * HT + 12) * DIV + 1);
    pulse_reset(1);
    run_clks(FRAME_CLK + 40);
    for (int i = 0; i < 6; i++) begin
      run_clks($urandom_range(1, 2 * FRAME_CLK));
      pulse_reset($urandom_range(1, 4));
    end
    run_clks(3 * FRAME_CLK + 20);
    run_clks(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
